request_arbiter: RTL and testbench

// - Single-port RAM request arbiter between the instruction-fetch and data-memory paths of the RV32I core.
// - Alternates between two kinds of access. Every instruction is fetched first. If that instruction is a load or store,
//   one data access follows before the next fetch.
// - Drives the shared RAM address, store-data and enable lines.
// - Returns fetched words on imemload and loaded words on dmmload.

---
 rtl/cpu_types_pkg.sv | 66 ++++++
 rtl/request_arbiter.sv | 109 ++++++++++
 tb/tb_request_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// ============================================================================
// Module      : cpu_types_pkg
// Description : RV32I control-unit opcode type shared across the core, plus
//               memory-operation classification helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

    localparam int c_WORD_W = 32;
    localparam int c_OP_W   = 6;

    typedef enum logic [c_OP_W-1:0] {
        CU_LUI,
        CU_AUIPC,
        CU_JAL,
        CU_JALR,
        CU_BEQ,
        CU_BNE,
        CU_BLT,
        CU_BGE,
        CU_BLTU,
        CU_BGEU,
        CU_LB,
        CU_LH,
        CU_LW,
        CU_LBU,
        CU_LHU,
        CU_SB,
        CU_SH,
        CU_SW,
        CU_ADDI,
        CU_SLTI,
        CU_SLTIU,
        CU_XORI,
        CU_ORI,
        CU_ANDI,
        CU_SLLI,
        CU_SRLI,
        CU_SRAI,
        CU_ADD,
        CU_SUB,
        CU_SLL,
        CU_SLT,
        CU_SLTU,
        CU_XOR,
        CU_SRL,
        CU_SRA,
        CU_OR,
        CU_AND,
        CU_ERROR
    } cuOPType;

    function automatic logic is_load(input cuOPType op);
        is_load = (op == CU_LB) || (op == CU_LH) || (op == CU_LW) ||
                  (op == CU_LBU) || (op == CU_LHU);
    endfunction

    function automatic logic is_store(input cuOPType op);
        is_store = (op == CU_SB) || (op == CU_SH) || (op == CU_SW);
    endfunction

endpackage

`default_nettype wire

// File: rtl/request_arbiter.sv
// ============================================================================
// Module      : request_arbiter
// Description : Single-port RAM arbiter alternating instruction fetches with
//               the one data access that follows each load/store instruction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module request_arbiter
    import cpu_types_pkg::*;
(
    input  logic                CLK,
    input  logic                nRST,
    input  logic                busy_o,
    input  logic [c_WORD_W-1:0] imemaddr,
    input  logic [c_WORD_W-1:0] dmmaddr,
    input  logic [c_WORD_W-1:0] dmmstore,
    input  logic [c_WORD_W-1:0] ramload,
    input  cuOPType             cuOP,
    output logic                Ren,
    output logic                Wen,
    output logic [c_WORD_W-1:0] imemload,
    output logic [c_WORD_W-1:0] dmmload,
    output logic [c_WORD_W-1:0] ramaddr,
    output logic [c_WORD_W-1:0] ramstore
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } req_state_t;

    req_state_t          r_state;
    logic                r_is_store;
    logic [c_WORD_W-1:0] r_imemload;
    logic [c_WORD_W-1:0] r_dmmload;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= IDLE;
            r_is_store <= 1'b0;
            r_imemload <= '0;
            r_dmmload  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= FETCH;
                end
                FETCH: begin
                    if (!busy_o) begin
                        r_imemload <= ramload;
                        // The op class is frozen here so the data access is
                        // immune to cuOP moving on while it is in flight.
                        if (is_load(cuOP)) begin
                            r_is_store <= 1'b0;
                            r_state    <= DATA;
                        end else if (is_store(cuOP)) begin
                            r_is_store <= 1'b1;
                            r_state    <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (!busy_o) begin
                        if (!r_is_store) begin
                            r_dmmload <= ramload;
                        end
                        r_state <= FETCH;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        Ren      = 1'b0;
        Wen      = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (r_state)
            FETCH: begin
                Ren     = 1'b1;
                ramaddr = imemaddr;
            end
            DATA: begin
                ramaddr = dmmaddr;
                if (r_is_store) begin
                    Wen      = 1'b1;
                    ramstore = dmmstore;
                end else begin
                    Ren = 1'b1;
                end
            end
            default: begin
                Ren = 1'b0;
            end
        endcase
    end

    assign imemload = r_imemload;
    assign dmmload  = r_dmmload;

endmodule

`default_nettype wire

// File: tb/tb_request_arbiter.sv
// ============================================================================
// Module      : tb_request_arbiter
// Description : Scoreboard bench for request_arbiter: directed scenarios then
//               randomized traffic against a transaction-level access model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_request_arbiter;
    import cpu_types_pkg::*;

    logic        tb_clk;
    logic        nRST;
    logic        busy_o;
    logic [31:0] imemaddr;
    logic [31:0] dmmaddr;
    logic [31:0] dmmstore;
    logic [31:0] ramload;
    cuOPType     cuOP;
    logic        Ren;
    logic        Wen;
    logic [31:0] imemload;
    logic [31:0] dmmload;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;

    request_arbiter dut (
        .CLK      (tb_clk),
        .nRST     (nRST),
        .busy_o   (busy_o),
        .imemaddr (imemaddr),
        .dmmaddr  (dmmaddr),
        .dmmstore (dmmstore),
        .ramload  (ramload),
        .cuOP     (cuOP),
        .Ren      (Ren),
        .Wen      (Wen),
        .imemload (imemload),
        .dmmload  (dmmload),
        .ramaddr  (ramaddr),
        .ramstore (ramstore)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    typedef struct {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] st;
        logic [31:0] im;
        logic [31:0] dm;
    } exp_t;

    exp_t expq[$];
    event ev_check;
    int   total = 0;
    int   bad   = 0;

    // Model: which access the RAM port should be serving right now.
    typedef enum int {K_NONE, K_FETCH, K_LOAD, K_STORE} kind_t;
    kind_t       m_kind = K_NONE;
    logic [31:0] m_imem = '0;
    logic [31:0] m_dmm  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(ev_check);
            #2;
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_empty: got 0 entries expected 1");
            end else begin
                e = expq.pop_front();
                check("Ren",      {31'd0, Ren},  {31'd0, e.ren});
                check("Wen",      {31'd0, Wen},  {31'd0, e.wen});
                check("ramaddr",  ramaddr,       e.addr);
                check("ramstore", ramstore,      e.st);
                check("imemload", imemload,      e.im);
                check("dmmload",  dmmload,       e.dm);
                check("ren_wen_exclusive", {31'd0, Ren & Wen}, 32'd0);
            end
        end
    end

    task automatic step(input logic b, input cuOPType op, input logic [31:0] ia,
                        input logic [31:0] da, input logic [31:0] ds,
                        input logic [31:0] rl, input logic rn);
        exp_t e;
        @(negedge tb_clk);
        busy_o   = b;
        cuOP     = op;
        imemaddr = ia;
        dmmaddr  = da;
        dmmstore = ds;
        ramload  = rl;
        nRST     = rn;
        if (!rn) begin
            m_kind = K_NONE;
            m_imem = '0;
            m_dmm  = '0;
        end
        e.ren  = (m_kind == K_FETCH) || (m_kind == K_LOAD);
        e.wen  = (m_kind == K_STORE);
        e.addr = (m_kind == K_FETCH) ? ia :
                 (m_kind == K_LOAD || m_kind == K_STORE) ? da : 32'd0;
        e.st   = (m_kind == K_STORE) ? ds : 32'd0;
        e.im   = m_imem;
        e.dm   = m_dmm;
        expq.push_back(e);
        ->ev_check;
        @(posedge tb_clk);
        if (rn) begin
            if (m_kind == K_NONE) begin
                m_kind = K_FETCH;
            end else if (!b) begin
                case (m_kind)
                    K_FETCH: begin
                        m_imem = rl;
                        if (op inside {CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU})
                            m_kind = K_LOAD;
                        else if (op inside {CU_SB, CU_SH, CU_SW})
                            m_kind = K_STORE;
                    end
                    K_LOAD: begin
                        m_dmm  = rl;
                        m_kind = K_FETCH;
                    end
                    default: m_kind = K_FETCH;
                endcase
            end
        end
    endtask

    function automatic cuOPType rand_op();
        cuOPType mem_ops [8] = '{CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU, CU_SB, CU_SH, CU_SW};
        if ($urandom_range(0, 1) == 0)
            return mem_ops[$urandom_range(0, 7)];
        return cuOPType'($urandom_range(0, 37));
    endfunction

    initial begin : stimulus
        nRST     = 1'b0;
        busy_o   = 1'b0;
        cuOP     = CU_ADD;
        imemaddr = '0;
        dmmaddr  = '0;
        dmmstore = '0;
        ramload  = '0;

        // Reset, then fetch followed by a load
        step(0, CU_ADD, 32'h0, 32'h0, 32'h0, 32'h0, 0);
        step(0, CU_ADD, 32'h0, 32'h0, 32'h0, 32'h0, 0);
        step(0, CU_LB, 32'hABCDABCD, 32'h0, 32'h0, 32'h12341234, 1);
        step(1, CU_LB, 32'hABCDABCD, 32'h0, 32'h0, 32'h12341234, 1);
        step(0, CU_LB, 32'hABCDABCD, 32'h0, 32'h0, 32'h12341234, 1);
        step(1, CU_LB, 32'h0, 32'h56785678, 32'h0, 32'h43214321, 1);
        step(0, CU_LB, 32'h0, 32'h56785678, 32'h0, 32'h43214321, 1);
        // Fetch followed by a store; dmmload must hold
        step(0, CU_SW, 32'h11111111, 32'h0, 32'h0, 32'h22222222, 1);
        step(0, CU_SW, 32'h0, 32'hABCDABCD, 32'h33333333, 32'h99999999, 1);
        // Five-cycle stall in FETCH, then a non-memory op
        for (int i = 0; i < 5; i++)
            step(1, CU_ADD, 32'h00000400, 32'h0, 32'h0, 32'hDEAD0000 + i, 1);
        step(0, CU_ADD, 32'h00000400, 32'h0, 32'h0, 32'h0BADF00D, 1);
        step(0, CU_ERROR, 32'h00000404, 32'h0, 32'h0, 32'h0C0FFEE0, 1);
        // Store op class latched despite cuOP switching to a load
        step(0, CU_SB, 32'h00000408, 32'h0, 32'h0, 32'h5B5B5B5B, 1);
        step(1, CU_LB, 32'h0, 32'h00002000, 32'h77777777, 32'h66666666, 1);
        step(0, CU_LB, 32'h0, 32'h00002000, 32'h77777777, 32'h66666666, 1);
        // Reset while a data access is in flight
        step(0, CU_SW, 32'h0000040C, 32'h0, 32'h0, 32'h12121212, 1);
        step(1, CU_ADD, 32'h0, 32'h00003000, 32'h44444444, 32'h0, 1);
        step(1, CU_ADD, 32'h0, 32'h00003000, 32'h44444444, 32'h0, 0);
        step(0, CU_ADD, 32'h00000500, 32'h0, 32'h0, 32'h0, 1);
        step(0, CU_ADD, 32'h00000500, 32'h0, 32'h0, 32'h31313131, 1);

        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 2) == 0), rand_op(), $urandom, $urandom,
                 $urandom, $urandom, ($urandom_range(0, 59) != 0));

        @(negedge tb_clk);
        #4;
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
